// File: rtl/sd_spi_cmd_ctrl.sv
// rtl/sd_spi_cmd_ctrl.sv - SD card SPI-mode command sequencer with R1 response polling
module sd_spi_cmd_ctrl #(
    parameter int CLK_DIV      = 4,
    parameter int RESP_TIMEOUT = 8,
    parameter int TRAIL_BITS   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [47:0] cmd,
    input  logic        start,
    output logic        busy,
    output logic [7:0]  response,
    output logic        responseByte,
    output logic        timeout,
    output logic        sd_cs_n,
    output logic        sd_sclk,
    output logic        sd_mosi,
    input  logic        sd_miso
);
    localparam int               DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [7:0]       TRAIL_LAST = 8'(TRAIL_BITS - 1);
    localparam logic [7:0]       POLL_LAST  = 8'(RESP_TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_POLL, S_TRAIL} state_t;

    state_t           r_state;
    state_t           w_next;

    logic             r_start_q;
    logic [46:0]      r_shift;
    logic [6:0]       r_rx;
    logic [DIV_W-1:0] r_div;
    logic [7:0]       r_bit_cnt;
    logic [7:0]       r_byte_cnt;
    logic             r_setup;
    logic             r_done;
    logic             r_sclk;
    logic             r_mosi;
    logic             r_cs_n;
    logic             r_busy;
    logic [7:0]       r_response;
    logic             r_resp_valid;
    logic             r_timeout;

    logic             w_accept;
    logic             w_tick;
    logic             w_sclk_rise;
    logic             w_sclk_fall;
    logic [7:0]       w_rx_byte;

    // The first cycle after acceptance only asserts cs_n/mosi; the half-period
    // counter starts one cycle later so the card sees setup time before SCLK.
    assign w_accept    = (r_state == S_IDLE) && start && !r_start_q;
    assign w_tick      = (r_state != S_IDLE) && !r_setup && (r_div == DIV_LAST);
    assign w_sclk_rise = w_tick && !r_sclk;
    assign w_sclk_fall = w_tick && r_sclk;
    assign w_rx_byte   = {r_rx, sd_miso};

    assign busy         = r_busy;
    assign response     = r_response;
    assign responseByte = r_resp_valid;
    assign timeout      = r_timeout;
    assign sd_cs_n      = r_cs_n;
    assign sd_sclk      = r_sclk;
    assign sd_mosi      = r_mosi;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; every phase ends on an SCLK falling edge so SCLK leaves low
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_SEND;
            S_SEND:  if (w_sclk_fall && r_bit_cnt == 8'd47) w_next = S_POLL;
            S_POLL:  if (w_sclk_fall && r_done) w_next = S_TRAIL;
            S_TRAIL: if (w_sclk_fall && r_bit_cnt == TRAIL_LAST) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // SCLK generation, command shift-out, response capture and trailing clocks
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_start_q    <= 1'b0;
            r_shift      <= '0;
            r_rx         <= '0;
            r_div        <= '0;
            r_bit_cnt    <= '0;
            r_byte_cnt   <= '0;
            r_setup      <= 1'b0;
            r_done       <= 1'b0;
            r_sclk       <= 1'b0;
            r_mosi       <= 1'b1;
            r_cs_n       <= 1'b1;
            r_busy       <= 1'b0;
            r_response   <= 8'hFF;
            r_resp_valid <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_start_q <= start;
            if (w_accept) begin
                r_shift      <= cmd[46:0];
                r_mosi       <= cmd[47];
                r_cs_n       <= 1'b0;
                r_busy       <= 1'b1;
                r_resp_valid <= 1'b0;
                r_timeout    <= 1'b0;
                r_setup      <= 1'b1;
                r_div        <= '0;
                r_sclk       <= 1'b0;
                r_bit_cnt    <= '0;
                r_byte_cnt   <= '0;
                r_done       <= 1'b0;
            end else if (r_state != S_IDLE) begin
                if (r_setup) begin
                    r_setup <= 1'b0;
                end else if (w_tick) begin
                    r_div  <= '0;
                    r_sclk <= ~r_sclk;
                end else begin
                    r_div <= r_div + DIV_W'(1);
                end

                case (r_state)
                    S_SEND: begin
                        if (w_sclk_fall) begin
                            if (r_bit_cnt == 8'd47) begin
                                r_mosi    <= 1'b1;
                                r_bit_cnt <= '0;
                            end else begin
                                r_mosi    <= r_shift[46];
                                r_shift   <= {r_shift[45:0], 1'b1};
                                r_bit_cnt <= r_bit_cnt + 8'd1;
                            end
                        end
                    end
                    S_POLL: begin
                        if (w_sclk_rise) begin
                            r_rx <= w_rx_byte[6:0];
                            if (r_bit_cnt == 8'd7) begin
                                r_bit_cnt <= '0;
                                if (w_rx_byte != 8'hFF) begin
                                    r_response   <= w_rx_byte;
                                    r_resp_valid <= 1'b1;
                                    r_done       <= 1'b1;
                                end else if (r_byte_cnt == POLL_LAST) begin
                                    r_response   <= 8'hFF;
                                    r_resp_valid <= 1'b0;
                                    r_timeout    <= 1'b1;
                                    r_done       <= 1'b1;
                                end else begin
                                    r_byte_cnt <= r_byte_cnt + 8'd1;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 8'd1;
                            end
                        end else if (w_sclk_fall && r_done) begin
                            // Release the card only once SCLK is back low
                            r_cs_n    <= 1'b1;
                            r_done    <= 1'b0;
                            r_bit_cnt <= '0;
                        end
                    end
                    S_TRAIL: begin
                        if (w_sclk_fall) begin
                            if (r_bit_cnt == TRAIL_LAST) begin
                                r_busy    <= 1'b0;
                                r_bit_cnt <= '0;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 8'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sd_spi_cmd_ctrl.sv
// tb/tb_sd_spi_cmd_ctrl.sv - self-checking bench for sd_spi_cmd_ctrl
module tb_sd_spi_cmd_ctrl;
    localparam int TMO = 8;
    localparam int TRL = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [47:0] cmd = '0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic        busy_a, rv_a, to_a, cs_a, sclk_a, mosi_a;
    logic        busy_b, rv_b, to_b, cs_b, sclk_b, mosi_b;
    logic [7:0]  resp_a, resp_b;
    logic        miso_a = 1'b1, miso_b = 1'b1;

    always #5 clk = ~clk;

    sd_spi_cmd_ctrl #(.CLK_DIV(2), .RESP_TIMEOUT(TMO), .TRAIL_BITS(TRL)) dut_a (
        .clk(clk), .reset(reset), .cmd(cmd), .start(start_a), .busy(busy_a),
        .response(resp_a), .responseByte(rv_a), .timeout(to_a), .sd_cs_n(cs_a),
        .sd_sclk(sclk_a), .sd_mosi(mosi_a), .sd_miso(miso_a));

    sd_spi_cmd_ctrl #(.CLK_DIV(1), .RESP_TIMEOUT(TMO), .TRAIL_BITS(TRL)) dut_b (
        .clk(clk), .reset(reset), .cmd(cmd), .start(start_b), .busy(busy_b),
        .response(resp_b), .responseByte(rv_b), .timeout(to_b), .sd_cs_n(cs_b),
        .sd_sclk(sclk_b), .sd_mosi(mosi_b), .sd_miso(miso_b));

    // Card models: poll bytes served MSB first after the 48 command clocks
    logic [7:0]  pa [0:15];
    logic [7:0]  pb [0:15];
    int          ka = 0, kb = 0;
    int          tot_a = 0, trl_a = 0, pm_a = 0, tot_b = 0, trl_b = 0, pm_b = 0;
    logic [47:0] cap_a = '0, cap_b = '0;

    always @(negedge cs_a) begin ka = 0; miso_a = 1'b1; end
    always @(posedge sclk_a) begin
        tot_a++;
        if (cs_a) begin
            trl_a++;
            miso_a = 1'b1;
        end else begin
            if (ka < 48) cap_a = {cap_a[46:0], mosi_a};
            else if (!mosi_a) pm_a++;
            ka++;
            if (ka >= 48 && (ka - 48) / 8 < 16) miso_a = pa[(ka - 48) / 8][7 - ((ka - 48) % 8)];
            else miso_a = 1'b1;
        end
    end

    always @(negedge cs_b) begin kb = 0; miso_b = 1'b1; end
    always @(posedge sclk_b) begin
        tot_b++;
        if (cs_b) begin
            trl_b++;
            miso_b = 1'b1;
        end else begin
            if (kb < 48) cap_b = {cap_b[46:0], mosi_b};
            else if (!mosi_b) pm_b++;
            kb++;
            if (kb >= 48 && (kb - 48) / 8 < 16) miso_b = pb[(kb - 48) / 8][7 - ((kb - 48) % 8)];
            else miso_b = 1'b1;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input int w, input logic [47:0] c, output int bcyc,
                           output logic acc_rv, output logic acc_to);
        int guard;
        @(negedge clk);
        cmd = c;
        if (w == 0) begin tot_a = 0; trl_a = 0; pm_a = 0; cap_a = '0; start_a = 1'b1; end
        else        begin tot_b = 0; trl_b = 0; pm_b = 0; cap_b = '0; start_b = 1'b1; end
        @(negedge clk);
        cmd    = ~c;
        acc_rv = (w == 0) ? rv_a : rv_b;
        acc_to = (w == 0) ? to_a : to_b;
        chk("accept_busy", (w == 0) ? busy_a : busy_b, 1);
        bcyc  = 0;
        guard = 0;
        while (((w == 0) ? busy_a : busy_b) && guard < 8000) begin
            bcyc++;
            guard++;
            @(negedge clk);
        end
        chk("busy_bounded", guard < 8000, 1);
    endtask

    task automatic check_a(input string tag, input logic [47:0] c, input int bcyc,
                           input logic [7:0] e_resp, input logic e_rv, input logic e_to, input int n);
        chk({tag, "_resp"}, resp_a, e_resp);
        chk({tag, "_valid"}, rv_a, e_rv);
        chk({tag, "_timeout"}, to_a, e_to);
        chk({tag, "_busy_cycles"}, bcyc, 1 + (48 + 8 * n + TRL) * 2 * 2);
        chk({tag, "_sclks"}, tot_a, 48 + 8 * n + TRL);
        chk({tag, "_mosi_cmd"}, cap_a, c);
        chk({tag, "_trail_sclks"}, trl_a, TRL);
        chk({tag, "_poll_mosi_low"}, pm_a, 0);
    endtask

    typedef struct {
        logic [47:0] c;
        int          pos;
        logic [7:0]  val;
        logic [7:0]  e_resp;
        logic        e_rv;
        logic        e_to;
        int          e_n;
    } vec_t;

    vec_t vecs [0:4];

    initial begin
        int          bcyc, busy_seen, guard, n;
        logic        arv, ato, found;
        logic [7:0]  e_resp;
        logic [47:0] rc;

        vecs[0] = '{48'h400000000095, 1, 8'h01, 8'h01, 1'b1, 1'b0, 2};
        vecs[1] = '{48'h48000001AA87, -1, 8'hFF, 8'hFF, 1'b0, 1'b1, 8};
        vecs[2] = '{48'h7A5A5A5A5AFF, 0, 8'h00, 8'h00, 1'b1, 1'b0, 1};
        vecs[3] = '{48'hC3C3C3C3C3C3, 7, 8'h3F, 8'h3F, 1'b1, 1'b0, 8};
        vecs[4] = '{48'h1234567890AB, 8, 8'h01, 8'hFF, 1'b0, 1'b1, 8};

        for (int i = 0; i < 16; i++) begin pa[i] = 8'hFF; pb[i] = 8'hFF; end

        repeat (3) @(negedge clk);
        chk("rst_cs_n", cs_a, 1);
        chk("rst_sclk", sclk_a, 0);
        chk("rst_mosi", mosi_a, 1);
        chk("rst_busy", busy_a, 0);
        chk("rst_resp", resp_a, 8'hFF);
        chk("rst_valid", rv_a, 0);
        chk("rst_timeout", to_a, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 16; i++) pa[i] = 8'hFF;
            if (vecs[v].pos >= 0) pa[vecs[v].pos] = vecs[v].val;
            run_txn(0, vecs[v].c, bcyc, arv, ato);
            check_a($sformatf("vec%0d", v), vecs[v].c, bcyc, vecs[v].e_resp, vecs[v].e_rv, vecs[v].e_to, vecs[v].e_n);
            start_a = 1'b0;
            @(negedge clk);
        end

        // Held start: timeout transaction, no retrigger, then a fresh edge clears flags
        for (int i = 0; i < 16; i++) pa[i] = 8'hFF;
        run_txn(0, 48'h4C0000000001, bcyc, arv, ato);
        chk("held_timeout", to_a, 1);
        busy_seen = 0;
        repeat (40) begin @(negedge clk); if (busy_a) busy_seen++; end
        chk("held_no_retrigger", busy_seen, 0);
        start_a = 1'b0;
        @(negedge clk);
        pa[0] = 8'h01;
        run_txn(0, 48'h400000000095, bcyc, arv, ato);
        chk("reedge_timeout_cleared", ato, 0);
        chk("reedge_valid_cleared", arv, 0);
        check_a("reedge", 48'h400000000095, bcyc, 8'h01, 1'b1, 1'b0, 1);
        start_a = 1'b0;
        @(negedge clk);

        // Start re-pulsed during SEND is ignored and not queued
        for (int i = 0; i < 16; i++) pa[i] = 8'hFF;
        pa[1] = 8'h01;
        fork
            run_txn(0, 48'h400000000095, bcyc, arv, ato);
            begin
                repeat (40) @(negedge clk);
                start_a = 1'b0;
                repeat (2) @(negedge clk);
                start_a = 1'b1;
            end
        join
        check_a("repulse", 48'h400000000095, bcyc, 8'h01, 1'b1, 1'b0, 2);
        busy_seen = 0;
        repeat (30) begin @(negedge clk); if (busy_a) busy_seen++; end
        chk("repulse_not_queued", busy_seen, 0);
        start_a = 1'b0;
        @(negedge clk);

        // Asynchronous reset at the 20th SCLK of SEND
        tot_a   = 0;
        start_a = 1'b1;
        guard   = 0;
        while (tot_a < 20 && guard < 1000) begin @(negedge clk); guard++; end
        chk("reset_reach_sclk20", guard < 1000, 1);
        reset = 1'b1;
        #1;
        chk("arst_cs_n", cs_a, 1);
        chk("arst_sclk", sclk_a, 0);
        chk("arst_mosi", mosi_a, 1);
        chk("arst_busy", busy_a, 0);
        chk("arst_resp", resp_a, 8'hFF);
        chk("arst_valid", rv_a, 0);
        @(negedge clk);
        reset   = 1'b0;
        start_a = 1'b0;
        @(negedge clk);
        run_txn(0, 48'h400000000095, bcyc, arv, ato);
        check_a("post_rst", 48'h400000000095, bcyc, 8'h01, 1'b1, 1'b0, 2);
        start_a = 1'b0;
        @(negedge clk);

        // CLK_DIV=1 instance, response on poll byte 3
        pb[2] = 8'h05;
        run_txn(1, 48'h5100000000FF, bcyc, arv, ato);
        chk("div1_resp", resp_b, 8'h05);
        chk("div1_valid", rv_b, 1);
        chk("div1_timeout", to_b, 0);
        chk("div1_busy_cycles", bcyc, 161);
        chk("div1_sclks", tot_b, 80);
        chk("div1_mosi_cmd", cap_b, 48'h5100000000FF);
        chk("div1_trail_sclks", trl_b, TRL);
        start_b = 1'b0;
        @(negedge clk);

        // Randomized transactions against the response-search model
        for (int t = 0; t < 10; t++) begin
            rc = {16'($urandom), $urandom};
            for (int i = 0; i < 16; i++)
                pa[i] = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : 8'hFF;
            found  = 1'b0;
            n      = TMO;
            e_resp = 8'hFF;
            for (int i = 0; i < TMO; i++) begin
                if (!found && pa[i] != 8'hFF) begin
                    found  = 1'b1;
                    n      = i + 1;
                    e_resp = pa[i];
                end
            end
            run_txn(0, rc, bcyc, arv, ato);
            check_a($sformatf("rand%0d", t), rc, bcyc, e_resp, found, !found, n);
            start_a = 1'b0;
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sd_spi_cmd_ctrl.md
Name: sd_spi_cmd_ctrl

Overview:
Sequences one SD-card SPI command transaction for the processor's memory-mapped SD interface. It takes the 48-bit command and start bit from the memory-map command registers, shifts the command out in SPI mode 0, and polls for the R1 response byte. It returns the byte and a valid flag to the memory map's response read register, then releases the card with trailing clocks. It sits between the memory-map SD registers and the board SPI pins.

Parameters:
CLK_DIV, 4, clk cycles per SCLK half-period (>=1); SCLK period = 2*CLK_DIV clk cycles.
RESP_TIMEOUT, 8, max response-poll bytes before giving up (1..255).
TRAIL_BITS, 8, SCLK pulses sent with cs_n high after each transaction.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cmd  in  48  command frame, bit 47 sent first; sampled when a start is accepted
start  in  1  level from the command register; its rising edge requests a transaction
busy  out  1  high from start acceptance until return to IDLE
response  out  8  last captured R1 byte
responseByte  out  1  high when response is valid; cleared on next accepted start
timeout  out  1  high if the last transaction got no response; cleared on next accepted start
sd_cs_n  out  1  SPI chip select, active low
sd_sclk  out  1  SPI clock, idles low
sd_mosi  out  1  SPI data to card, idles high
sd_miso  in  1  SPI data from card

Behaviour:
- Reset (async, any state): state=IDLE, sd_cs_n=1, sd_sclk=0, sd_mosi=1, busy=0, response=8'hFF, responseByte=0, timeout=0, and all counters and the shift register cleared. Reset mid-transaction aborts immediately; no trailing clocks are sent.
- Start detect: a registered copy of start; rise = start & ~start_q.
  - A rise in IDLE is accepted.
  - A rise in any other state is ignored and not queued.
  - start held high after completion does not retrigger.
- SPI mode 0. A half-period counter counts 0..CLK_DIV-1.
  - sd_sclk toggles when the counter wraps.
  - sd_mosi changes only on sclk falling edges (and on SEND entry).
  - sd_miso is sampled on sclk rising edges.
- States:
  - IDLE: on accepted rise, load shift register with cmd, clear responseByte and timeout, set busy=1, sd_cs_n=0, sd_mosi=cmd[47], and go to SEND on the next clk.
  - SEND: 48 SCLK pulses, MSB first. After the 48th falling edge, go to POLL with sd_mosi=1.
  - POLL: clock whole bytes with sd_mosi=1, shifting in sd_miso MSB first.
    - At each byte boundary (8th rising edge, after that edge's sample), a byte != 8'hFF is latched into response, sets responseByte=1, and moves to TRAIL.
    - Otherwise the byte count increments. At RESP_TIMEOUT bytes, response=8'hFF, timeout=1, responseByte=0, and the state moves to TRAIL.
    - Response detection is byte-aligned only.
  - TRAIL: sd_cs_n=1, sd_mosi=1, TRAIL_BITS SCLK pulses. After the last falling edge, go to IDLE with busy=0.
- Each state leaves with sd_sclk low.
- response, responseByte and timeout are held until the next accepted start.
- responseByte and response update in the same clk edge.
- Transaction duration (response on poll byte n, 1-based): 1 + (48 + 8n + TRAIL_BITS)*2*CLK_DIV clk cycles from accepted rise to busy falling.
- The cmd input may change freely while busy; only the accept-cycle value is used.

Test Plan:
1. CLK_DIV=2, cmd=48'h400000000095, start 0->1, miso=1 for poll byte 1 then 8'h01.
   - MOSI bits captured on rising sclk equal cmd MSB-first.
   - response=8'h01, responseByte=1, timeout=0.
   - busy high for 1+(48+16+8)*4=289 cycles; total sclk rising edges = 72.
2. miso stuck 1, RESP_TIMEOUT=8.
   - timeout=1, response=8'hFF, responseByte=0 after 8 poll bytes; 64 poll sclks.
   - cs_n high during 8 trailing clocks, then busy=0.
3. start held high through completion, then a second 0->1 edge.
   - No retrigger while held.
   - The second edge starts a new transaction and clears responseByte and timeout on acceptance.
4. Start pulsed 0->1->0->1 during SEND.
   - Second rise ignored; exactly one transaction (72 sclks in scenario 1 conditions).
5. reset asserted at the 20th sclk of SEND.
   - Outputs take reset values asynchronously (cs_n=1, sclk=0, mosi=1, busy=0, response=8'hFF).
   - The next start runs a full clean transaction.
6. miso returns 8'h05 on poll byte 3 with bytes 1-2 = 8'hFF; CLK_DIV=1.
   - response=8'h05, responseByte=1.
   - busy duration 1+(48+24+8)*2=161 cycles.
